// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the multicycle ARM datapath: 4-bit micro-PC,
// decode dispatch, instruction-completion strobe, retired count, illegal-op flag.
module micro_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  output logic [3:0]       adr,
  output logic             instrDone,
  output logic             illegalOp,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWRITE = 4'd4,
    MEMWB    = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state, next;
  logic   set_illegal;
  logic   terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next        = state;
    set_illegal = 1'b0;
    if (!stall) begin
      case (state)
        FETCH:   next = DECODE;
        DECODE: begin
          case (op)
            2'b00:   next = funct[5] ? EXECI : EXECR;
            2'b01:   next = MEMADR;
            2'b10:   next = BRANCH;
            default: begin
              next        = FETCH;
              set_illegal = 1'b1;
            end
          endcase
        end
        MEMADR:  next = funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD: next = MEMWB;
        EXECR:   next = ALUWB;
        EXECI:   next = ALUWB;
        // Terminal states and any unreachable encoding fall back to Fetch.
        default: next = FETCH;
      endcase
    end
  end

  always_comb begin
    adr       = state;
    terminal  = (state == MEMWB) || (state == MEMWRITE) ||
                (state == ALUWB) || (state == BRANCH);
    instrDone = terminal && !stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired   <= '0;
      illegalOp <= 1'b0;
    end else begin
      if (instrDone)   retired   <= retired + CNT_W'(1);
      if (set_illegal) illegalOp <= 1'b1;
    end
  end

endmodule
